kgp_regfile_sb: RTL and testbench

//  Parametrised multi-read-port register file for the KGP RISC pipeline, with a per-register

---
 rtl/kgp_rf_pkg.sv | 18 +
 rtl/kgp_rf_scoreboard.sv | 58 +++++
 rtl/kgp_regfile_sb.sv | 93 +++++++++
 tb/tb_kgp_regfile_sb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/kgp_rf_pkg.sv
// rtl/kgp_rf_pkg.sv - shared register-file defaults and typedefs for decode/writeback
// Macro KGP_RF_ZERO_REG_EN hardwires r0 to zero when defined.
package kgp_rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

`ifdef KGP_RF_ZERO_REG_EN
  localparam bit RF_ZERO_REG = 1'b1;
`else
  localparam bit RF_ZERO_REG = 1'b0;
`endif

endpackage

// File: rtl/kgp_rf_scoreboard.sv
// rtl/kgp_rf_scoreboard.sv - pending-write busy vector, issue acceptance and busy count
// r0 handling follows KGP_RF_ZERO_REG_EN through kgp_rf_pkg::RF_ZERO_REG.
module kgp_rf_scoreboard
  import kgp_rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  input  logic                issueEn,
  input  logic [ADDR_W-1:0]   issueAddr,
  output logic                issueOk,
  output logic                wrAccept,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     pendCnt
);

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);

  logic wrInRange, wrZero, issueInRange, issueZero;
  logic busyAtIssue, busyAtWr, issueSet, wrClears;

  assign wrInRange    = {1'b0, wrAddr} < NumRegsW;
  assign issueInRange = {1'b0, issueAddr} < NumRegsW;
  assign wrZero       = RF_ZERO_REG && (wrAddr == '0);
  assign issueZero    = RF_ZERO_REG && (issueAddr == '0);

  assign wrAccept    = wrEn && wrInRange && !wrZero;
  assign busyAtIssue = issueInRange ? busy[issueAddr] : 1'b0;
  assign busyAtWr    = wrInRange ? busy[wrAddr] : 1'b0;

  // A busy destination may be reissued only when its pending write lands this cycle.
  assign issueOk  = issueZero ||
                    (issueInRange && (!busyAtIssue || (wrEn && wrAddr == issueAddr)));
  assign issueSet = issueEn && issueOk && !issueZero;
  assign wrClears = wrAccept && busyAtWr;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      pendCnt <= '0;
    end else begin
      if (wrAccept) busy[wrAddr] <= 1'b0;
      // Issue after write so a same-cycle reissue leaves the bit set.
      if (issueSet) busy[issueAddr] <= 1'b1;
      case ({issueSet, wrClears})
        2'b10:   pendCnt <= pendCnt + CntOne;
        2'b01:   pendCnt <= pendCnt - CntOne;
        default: pendCnt <= pendCnt;
      endcase
    end
  end

endmodule

// File: rtl/kgp_regfile_sb.sv
// rtl/kgp_regfile_sb.sv - multi-read-port register file with write bypass and scoreboard
// Macro KGP_RF_ZERO_REG_EN (via kgp_rf_pkg) makes r0 read as constant zero.
module kgp_regfile_sb
  import kgp_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int OBS_REG  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ok,
  output logic [ADDR_W:0]          pend_cnt,
  output logic [DATA_W-1:0]        obs_out
);

  localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ObsAddr  = ADDR_W'(OBS_REG);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wrAccept;

  kgp_rf_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (wr_en),
    .wrAddr   (wr_addr),
    .issueEn  (issue_en),
    .issueAddr(issue_addr),
    .issueOk  (issue_ok),
    .wrAccept (wrAccept),
    .busy     (busy),
    .pendCnt  (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      obs_out <= '0;
    end else if (wrAccept) begin
      regs[wr_addr] <= wr_data;
      // obs_out tracks the same edge as the storage write, never lagging it.
      if (wr_addr == ObsAddr) obs_out <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] rAddr;
    logic              rInRange, rZero, rBypass, rReady;
    logic [DATA_W-1:0] rData;

    assign rAddr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign rInRange = {1'b0, rAddr} < NumRegsW;
    assign rZero    = RF_ZERO_REG && (rAddr == '0);
    assign rBypass  = wr_en && (wr_addr == rAddr);

    always_comb begin
      rData  = '0;
      rReady = 1'b0;
      if (!rInRange) begin
        rData  = '0;
        rReady = 1'b0;
      end else if (rZero) begin
        rData  = '0;
        rReady = 1'b1;
      end else if (rBypass) begin
        rData  = wr_data;
        rReady = 1'b1;
      end else begin
        rData  = regs[rAddr];
        rReady = !busy[rAddr];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rData;
    assign rd_ready[k]                 = rReady;
  end

endmodule

// File: tb/tb_kgp_regfile_sb.sv
// tb/tb_kgp_regfile_sb.sv - directed self-checking bench for kgp_regfile_sb
// Expectations for r0 follow KGP_RF_ZERO_REG_EN when it is defined for the build.
module tb_kgp_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     issue_ok;
  logic [ADDR_W:0]          pend_cnt;
  logic [DATA_W-1:0]        obs_out;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  kgp_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .issue_ok  (issue_ok),
    .pend_cnt  (pend_cnt),
    .obs_out   (obs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  task automatic setRd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0;
    tick();
    rst = 1'b0;

    // 1. random writes and an issue, then a single reset cycle wipes them
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i * 3); wr_data = $urandom;
      tick();
    end
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0BAD_0BAD;
    issue_en = 1'b1; issue_addr = 5'd20;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      setRd(ADDR_W'(a), ADDR_W'(a + 1));
      check($sformatf("rst_data_r%0d", a), 64'(rd_data), 64'h0);
      check($sformatf("rst_ready_r%0d", a), 64'(rd_ready), 64'h3);
    end
    check("rst_pend_cnt", 64'(pend_cnt), 64'h0);
    check("rst_obs_out", 64'(obs_out), 64'h0);

    // 2. same-cycle write/read bypass, then stored value
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    setRd(5'd5, 5'd6);
    check("byp_data0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    check("byp_ready0", 64'(rd_ready[0]), 64'h1);
    check("byp_port1_other", 64'(rd_data[63:32]), 64'h0);
    tick();
    idle();
    #1;
    check("stored_data0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    check("stored_ready0", 64'(rd_ready[0]), 64'h1);

    // 3. issue, stalled reissue, write clears
    issue_en = 1'b1; issue_addr = 5'd7;
    #1;
    check("iss7_ok", 64'(issue_ok), 64'h1);
    tick();
    setRd(5'd7, 5'd5);
    check("iss7_pend", 64'(pend_cnt), 64'h1);
    check("iss7_ready", 64'(rd_ready), 64'h2);
    check("iss7_again_ok", 64'(issue_ok), 64'h0);
    tick();
    issue_en = 1'b0;
    #1;
    check("iss7_stall_pend", 64'(pend_cnt), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    setRd(5'd7, 5'd7);
    check("wr7_byp_ready", 64'(rd_ready), 64'h3);
    check("wr7_byp_data1", 64'(rd_data[63:32]), 64'h55);
    tick();
    idle();
    #1;
    check("wr7_ready", 64'(rd_ready[0]), 64'h1);
    check("wr7_data", 64'(rd_data[31:0]), 64'h55);
    check("wr7_pend", 64'(pend_cnt), 64'h0);

    // 4. write and reissue r9 in the same cycle: new producer wins
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    issue_en = 1'b0;
    #1;
    check("iss9_pend", 64'(pend_cnt), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234;
    issue_en = 1'b1; issue_addr = 5'd9;
    #1;
    check("wi9_ok", 64'(issue_ok), 64'h1);
    tick();
    idle();
    setRd(5'd9, 5'd9);
    check("wi9_data", 64'(rd_data[31:0]), 64'h1234);
    check("wi9_ready", 64'(rd_ready), 64'h0);
    check("wi9_pend", 64'(pend_cnt), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1235;
    tick();
    idle();
    #1;
    check("wr9_pend", 64'(pend_cnt), 64'h0);

    // 5. observation port follows r12 only
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE_F00D;
    #1;
    check("obs_before_edge", 64'(obs_out), 64'h0);
    tick();
    check("obs_r12", 64'(obs_out), 64'hCAFE_F00D);
    wr_addr = 5'd13; wr_data = 32'h1111_2222;
    tick();
    idle();
    #1;
    check("obs_r13_unchanged", 64'(obs_out), 64'hCAFE_F00D);

    // 6. r0 write then issue
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    idle();
    issue_en = 1'b1; issue_addr = 5'd0;
    #1;
    check("r0_issue_ok", 64'(issue_ok), 64'h1);
    tick();
    idle();
    setRd(5'd0, 5'd13);
`ifdef KGP_RF_ZERO_REG_EN
    check("r0_data", 64'(rd_data[31:0]), 64'h0);
    check("r0_ready", 64'(rd_ready[0]), 64'h1);
    check("r0_pend", 64'(pend_cnt), 64'h0);
`else
    check("r0_data", 64'(rd_data[31:0]), 64'hFFFF_FFFF);
    check("r0_ready", 64'(rd_ready[0]), 64'h0);
    check("r0_pend", 64'(pend_cnt), 64'h1);
`endif
    check("r13_data", 64'(rd_data[63:32]), 64'h1111_2222);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
